// File: rtl/p19_nanov_muldiv_serial.sv
// Bit-serial RV32M multiply/divide unit for the nanoV core family.
// Operands and result stream LSB first. Each CALC cycle performs one shift-add or restoring-divide step.
module p19_nanov_muldiv_serial #(
    parameter int XLEN   = 32,
    parameter int DIV_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       rs1_in,
    input  logic       rs2_in,
    input  logic       kill,
    output logic       busy,
    output logic       rd_valid,
    output logic       rd_out,
    output logic       rd_last
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PREP = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_POST = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]      state_r;
    logic [2:0]      state_s;
    logic [CW-1:0]   cnt_r;
    logic [2:0]      op_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] res_r;
    logic            neg_r;
    logic            div0_r;

    logic            cnt_last_s;
    logic            a_signed_s;
    logic            b_signed_s;
    logic            sa_s;
    logic            sb_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] result_s;

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic en);
        return en ? ({XLEN{1'b0}} - v) : v;
    endfunction

    assign cnt_last_s = (cnt_r == CNT_LAST);
    assign busy       = (state_r != S_IDLE);
    assign rd_valid   = (state_r == S_OUT);
    assign rd_out     = rd_valid & res_r[0];
    assign rd_last    = rd_valid & cnt_last_s;

    // Operand signedness per funct3; MULHSU treats only rs1 as signed.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_r)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'd2: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign sa_s = a_signed_s & a_r[XLEN-1];
    assign sb_s = b_signed_s & b_r[XLEN-1];

    // One iteration step for each datapath; a_r doubles as P_lo (mul) and dividend/quotient (div).
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (a_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, a_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
    end

    // Sign fix-up and result selection; the remainder naturally equals rs1 on divide-by-zero.
    always_comb begin
        prod_s   = {acc_r, a_r};
        result_s = {XLEN{1'b0}};
        if (neg_r) begin
            prod_s = {(2*XLEN){1'b0}} - prod_s;
        end else begin
            prod_s = {acc_r, a_r};
        end
        case (op_r)
            3'd0:             result_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result_s = div0_r ? {XLEN{1'b1}} : negate_if(a_r, neg_r);
            3'd6, 3'd7:       result_s = negate_if(acc_r, neg_r);
            default:          result_s = {XLEN{1'b0}};
        endcase
        if ((DIV_EN == 0) && op_r[2]) begin
            result_s = {XLEN{1'b0}};
        end else begin
            result_s = result_s;
        end
    end

    // Next-state decode; kill overrides everything, including a same-cycle start.
    always_comb begin
        state_s = state_r;
        if (kill) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_s = start ? S_LOAD : S_IDLE;
                S_LOAD:  state_s = cnt_last_s ? S_PREP : S_LOAD;
                S_PREP:  state_s = S_CALC;
                S_CALC:  state_s = cnt_last_s ? S_POST : S_CALC;
                S_POST:  state_s = S_OUT;
                S_OUT:   state_s = cnt_last_s ? S_IDLE : S_OUT;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // State, counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
            op_r    <= 3'd0;
            a_r     <= {XLEN{1'b0}};
            b_r     <= {XLEN{1'b0}};
            acc_r   <= {XLEN{1'b0}};
            res_r   <= {XLEN{1'b0}};
            neg_r   <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (kill) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                case (state_r)
                    S_IDLE: begin
                        cnt_r <= {CW{1'b0}};
                        if (start) begin
                            op_r <= op;
                        end else begin
                            op_r <= op_r;
                        end
                    end
                    S_LOAD: begin
                        cnt_r <= cnt_last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        a_r   <= {rs1_in, a_r[XLEN-1:1]};
                        b_r   <= {rs2_in, b_r[XLEN-1:1]};
                    end
                    S_PREP: begin
                        cnt_r  <= {CW{1'b0}};
                        a_r    <= negate_if(a_r, sa_s);
                        b_r    <= negate_if(b_r, sb_s);
                        acc_r  <= {XLEN{1'b0}};
                        neg_r  <= (op_r[2] && op_r[1]) ? sa_s : (sa_s ^ sb_s);
                        div0_r <= (b_r == {XLEN{1'b0}});
                    end
                    S_CALC: begin
                        cnt_r <= cnt_last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (!op_r[2]) begin
                            acc_r <= mul_sum_s[XLEN:1];
                            a_r   <= {mul_sum_s[0], a_r[XLEN-1:1]};
                        end else if (DIV_EN != 0) begin
                            acc_r <= div_diff_s[XLEN] ? div_shift_s[XLEN-1:0] : div_diff_s[XLEN-1:0];
                            a_r   <= {a_r[XLEN-2:0], ~div_diff_s[XLEN]};
                        end else begin
                            acc_r <= acc_r;
                        end
                    end
                    S_POST: begin
                        cnt_r <= {CW{1'b0}};
                        res_r <= result_s;
                    end
                    S_OUT: begin
                        cnt_r <= cnt_last_s ? {CW{1'b0}} : cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        res_r <= {1'b0, res_r[XLEN-1:1]};
                    end
                    default: begin
                        cnt_r <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_p19_nanov_muldiv_serial.sv
// Scoreboard bench for p19_nanov_muldiv_serial (XLEN=32): directed RV32M vectors,
// latency, kill, reset-during-output and start-while-busy.
module tb_p19_nanov_muldiv_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       rs1_in = 1'b0;
    logic       rs2_in = 1'b0;
    logic       kill = 1'b0;
    logic       busy, rd_valid, rd_out, rd_last;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] got_word = 32'd0;
    int          bitcnt = 0;

    p19_nanov_muldiv_serial #(.XLEN(32), .DIV_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .kill(kill), .busy(busy), .rd_valid(rd_valid), .rd_out(rd_out), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: assemble serial results and compare against the scoreboard queue.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (bitcnt < 32) got_word[bitcnt] = rd_out;
            if (rd_last) begin
                check("rd_last_position", 32'(bitcnt), 32'd31);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    check(name_q.pop_front(), got_word, exp_q.pop_front());
                end
                bitcnt = 0;
            end else begin
                bitcnt++;
            end
        end else begin
            bitcnt = 0;
            check("idle_outputs_zero", {30'd0, rd_last, rd_out}, 32'd0);
        end
    end

    // mode 0: plain op; 1: extra start pulse while busy; 2: rst asserted during OUT
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int mode);
        int cyc;
        if (mode != 2) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        @(negedge clk);
        op = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            rs1_in = a[i];
            rs2_in = b[i];
            if (busy) cyc++;
            @(negedge clk);
        end
        rs1_in = 1'b0;
        rs2_in = 1'b0;
        while (busy && cyc < 200) begin
            if (mode == 1 && cyc == 50) begin
                start = 1'b1;
                op = 3'd0;
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && cyc == 75) begin
                check("rd_valid_before_rst", {31'd0, rd_valid}, 32'd1);
                rst = 1'b1;
                #1;
                check("outputs_in_rst", {28'd0, busy, rd_valid, rd_out, rd_last}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 32'(cyc), 32'd98);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, busy, rd_valid, rd_out, rd_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        run_op("mul_7_m3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("mulh_min_min",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op("mulhu_min_min",   3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op("mulhsu_m1_2",     3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0);
        run_op("mulhu_max_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("div_m7_2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op("rem_m7_2",        3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op("divu_100_7",      3'd5, 32'd100,      32'd7,        32'd14,       0);
        run_op("remu_100_7",      3'd7, 32'd100,      32'd7,        32'd2,        0);
        run_op("div_5_0",         3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("rem_5_0",         3'd6, 32'd5,        32'd0,        32'd5,        0);
        run_op("div_m7_0",        3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 0);
        run_op("rem_m7_0",        3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0);
        run_op("remu_m7_0",       3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0);
        run_op("div_ovf",         3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem_ovf",         3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

        // start and kill together in IDLE: kill wins
        @(negedge clk);
        start = 1'b1;
        kill = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill = 1'b0;
        check("start_kill_idle_busy", {31'd0, busy}, 32'd0);

        // kill mid-CALC, then an immediate new multiply
        op = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_in = (i == 0 || i == 2) ? 1'b1 : 1'b0;
            rs2_in = (i == 0 || i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_rd_valid", {30'd0, busy, rd_valid}, 32'd0);
        run_op("mul_3_4_after_kill", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // reset during OUT discards the stream; next op must be clean
        run_op("divu_rst", 3'd5, 32'd100, 32'd7, 32'd0, 2);
        run_op("mul_after_rst", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0);

        // start while busy: ignored, only one result
        run_op("divu_start_busy", 3'd5, 32'd1000, 32'd10, 32'd100, 1);

        repeat (120) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
